// File: rtl/ad9826_spi_responder_pkg.sv
// -----------------------------------------------------------------------------
// ad9826_spi_responder_pkg
// Shared constants and FSM encoding for the AD9826-style 3-wire configuration
// port responder.
//   FRAME_BITS : serial frame length (R/W, 3-bit address, 3 don't-care, 9 data)
//   CMD_BITS   : leading command bits (R/W + address + don't-care)
//   DATA_BITS  : register width
//   ADDR_BITS  : register address width
//   CNT_BITS   : width of the frame bit counter (must hold FRAME_BITS)
// -----------------------------------------------------------------------------
package ad9826_spi_responder_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 7;
    localparam int DATA_BITS  = 9;
    localparam int ADDR_BITS  = 3;
    localparam int CNT_BITS   = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WDATA   = 3'd2,
        ST_RDATA   = 3'd3,
        ST_WAIT_HI = 3'd4
    } state_e;

endpackage

// File: rtl/ad9826_spi_responder_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Multi-flop synchronizer for one asynchronous pin plus single-cycle edge
// pulses derived from the synchronized level.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   i_d       : asynchronous input pin
//   o_sync    : synchronized level (STAGES flops after the pin)
//   o_rise    : one-cycle pulse in the cycle after o_sync goes 0 -> 1
//   o_fall    : one-cycle pulse in the cycle after o_sync goes 1 -> 0
// Parameters:
//   STAGES    : synchronizer depth (2..4)
//   RESET_VAL : value the chain and edge history reset to, so that the idle
//               level of the pin produces no spurious edge out of reset
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    // Both inputs are flops, so the pulses are glitch-free and last one cycle.
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/ad9826_spi_responder.sv
// -----------------------------------------------------------------------------
// ad9826_spi_responder
// Oversampling responder for the AD9826 3-wire configuration port. Frames are
// 16 bits MSB first: R/W (1 = read), address[2:0], 3 don't-care, data[8:0].
// Writes update a 9-bit register file; reads shift the addressed register out
// on sdata_o, changing on sclk falling edges.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   sclk_in       : serial clock from the initiator (asynchronous)
//   sload_in      : frame select, active low (asynchronous)
//   sdata_in      : serial data in, sampled on sclk rising edge
//   sdata_o       : read-back data bit
//   sdata_oe      : high while sdata_o is driven (first data fall .. sload rise)
//   regs_o        : flattened register file, reg[k] at [9k+8:9k]
//   wr_strobe_o   : one-cycle pulse when a write commits
//   wr_addr_o     : address of the last committed write
//   wr_data_o     : data of the last committed write
//   frame_err_o   : one-cycle pulse when a frame is cut short by sload rising
// Parameters:
//   SYNC_STAGES   : synchronizer depth on the serial pins (2..4)
//   NUM_REGS      : number of registers in the file
// sclk high and low phases must each last at least SYNC_STAGES+1 clk periods.
// -----------------------------------------------------------------------------
module ad9826_spi_responder
    import ad9826_spi_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sclk_in,
    input  logic                          sload_in,
    input  logic                          sdata_in,
    output logic                          sdata_o,
    output logic                          sdata_oe,
    output logic [DATA_BITS*NUM_REGS-1:0] regs_o,
    output logic                          wr_strobe_o,
    output logic [ADDR_BITS-1:0]          wr_addr_o,
    output logic [DATA_BITS-1:0]          wr_data_o,
    output logic                          frame_err_o
);

    localparam logic [CNT_BITS-1:0] CNT_ONE      = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_CMD_LAST = CNT_BITS'(CMD_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST_BIT = CNT_BITS'(FRAME_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_DONE     = CNT_BITS'(FRAME_BITS);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_sclk_level_unused;   // only sclk edges matter
    logic w_sload_sync;
    logic w_sload_rise;
    logic w_sload_fall_unused;   // frame start is level-qualified, see w_start
    logic w_sdata_sync;

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (sclk_in),
        .o_sync (w_sclk_level_unused),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sload_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (sload_in),
        .o_sync (w_sload_sync),
        .o_rise (w_sload_rise),
        .o_fall (w_sload_fall_unused)
    );

    // sdata has the same depth as sclk so a rise_evt sees the bit that was on
    // the pin when sclk rose.
    logic [SYNC_STAGES-1:0] r_sdata_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdata_sync <= '0;
        end else begin
            r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], sdata_in};
        end
    end

    assign w_sdata_sync = r_sdata_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Arming: the sload synchronizer resets to 1, which says nothing about
    // the real pin. r_warm marks when the chain holds genuine samples; only a
    // genuinely observed sload-high arms frame decoding. This keeps a frame
    // that was in flight across reset from being decoded or flagged.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_warm;
    logic                   r_armed;
    logic                   w_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_warm  <= {r_warm[SYNC_STAGES-2:0], 1'b1};
            r_armed <= r_armed | (r_warm[SYNC_STAGES-1] & w_sload_sync);
        end
    end

    assign w_start = r_armed & ~w_sload_sync;

    // ------------------------------------------------------------------
    // Frame datapath state
    // ------------------------------------------------------------------
    state_e                 r_state;
    state_e                 w_state_next;
    logic [CNT_BITS-1:0]    r_cnt;
    // Holds the last CMD_BITS-1 command bits; R/W is consumed on the fly when
    // the seventh bit arrives, leaving address and don't-care bits here.
    logic [CMD_BITS-2:0]    r_cmd;
    logic [CMD_BITS-1:0]    w_cmd_shift;
    logic [ADDR_BITS-1:0]   w_addr;
    logic [DATA_BITS-1:0]   r_wdata;
    logic                   r_rd_started;
    logic                   w_commit;
    logic                   w_abort;
    logic [DATA_BITS-1:0]   w_rd_word;

    assign w_cmd_shift = {r_cmd, w_sdata_sync};
    assign w_addr      = r_cmd[CMD_BITS-2 -: ADDR_BITS];
    // All 16 bits are in: commit in this cycle, one cycle after the last
    // rise_evt. Completion wins over a coincident sload rise.
    assign w_commit    = (r_state == ST_WDATA) && (r_cnt == CNT_DONE);
    assign w_abort     = w_sload_rise && !w_commit &&
                         ((r_state == ST_CMD) || (r_state == ST_WDATA) ||
                          (r_state == ST_RDATA));

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_sload_rise) begin
                    w_state_next = ST_IDLE;
                end else if (w_sclk_rise && (r_cnt == CNT_CMD_LAST)) begin
                    w_state_next = w_cmd_shift[CMD_BITS-1] ? ST_RDATA : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (w_commit) begin
                    w_state_next = ST_WAIT_HI;
                end else if (w_sload_rise) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (w_sload_rise) begin
                    w_state_next = ST_IDLE;
                end else if (w_sclk_rise && (r_cnt == CNT_LAST_BIT)) begin
                    w_state_next = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                // Level test: also covers a sload rise that landed on the
                // commit cycle, and exits in the same cycle as the rise_evt.
                if (w_sload_sync) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bit counter, command and write-data shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_wdata      <= '0;
            r_rd_started <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rd_started <= 1'b0;
                    // An sclk rise coinciding with frame start is bit 15.
                    if (w_start && w_sclk_rise) begin
                        r_cmd <= w_cmd_shift[CMD_BITS-2:0];
                        r_cnt <= CNT_ONE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_CMD: begin
                    if (!w_sload_rise && w_sclk_rise) begin
                        r_cmd <= w_cmd_shift[CMD_BITS-2:0];
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_WDATA: begin
                    if (!w_commit && !w_sload_rise && w_sclk_rise) begin
                        r_wdata <= {r_wdata[DATA_BITS-2:0], w_sdata_sync};
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_RDATA: begin
                    // sdata_in is deliberately not sampled while reading.
                    if (!w_sload_rise && w_sclk_rise) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    if (!w_sload_rise && w_sclk_fall) begin
                        r_rd_started <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_BITS-1:0] r_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_reg <= '0;
                end else if (w_commit && (w_addr == ADDR_BITS'(gi))) begin
                    r_reg <= r_wdata;
                end
            end

            assign regs_o[gi*DATA_BITS +: DATA_BITS] = r_reg;
        end
    endgenerate

    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_addr == ADDR_BITS'(k)) begin
                w_rd_word = regs_o[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: next values computed combinationally, then registered
    // ------------------------------------------------------------------
    // D8 goes straight to sdata_o on load, so only D7..D0 are kept here.
    logic [DATA_BITS-2:0]   r_sout;
    logic [DATA_BITS-2:0]   w_sout_next;
    logic                   w_sdata_next;
    logic                   w_oe_next;
    logic                   w_strobe_next;
    logic [ADDR_BITS-1:0]   w_wr_addr_next;
    logic [DATA_BITS-1:0]   w_wr_data_next;
    logic                   w_err_next;

    always_comb begin
        w_sout_next    = r_sout;
        w_sdata_next   = sdata_o;
        w_oe_next      = sdata_oe;
        w_strobe_next  = 1'b0;
        w_wr_addr_next = wr_addr_o;
        w_wr_data_next = wr_data_o;
        w_err_next     = w_abort;

        if (w_commit) begin
            w_strobe_next  = 1'b1;
            w_wr_addr_next = w_addr;
            w_wr_data_next = r_wdata;
        end

        if ((r_state == ST_RDATA) && !w_sload_rise && w_sclk_fall) begin
            if (!r_rd_started) begin
                w_sout_next  = w_rd_word[DATA_BITS-2:0];
                w_sdata_next = w_rd_word[DATA_BITS-1];
                w_oe_next    = 1'b1;
            end else begin
                w_sout_next  = {r_sout[DATA_BITS-3:0], 1'b0};
                w_sdata_next = r_sout[DATA_BITS-2];
            end
        end

        // Release the data line the moment the FSM heads back to IDLE.
        if (w_state_next == ST_IDLE) begin
            w_oe_next    = 1'b0;
            w_sdata_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sout      <= '0;
            sdata_o     <= 1'b0;
            sdata_oe    <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            frame_err_o <= 1'b0;
        end else begin
            r_sout      <= w_sout_next;
            sdata_o     <= w_sdata_next;
            sdata_oe    <= w_oe_next;
            wr_strobe_o <= w_strobe_next;
            wr_addr_o   <= w_wr_addr_next;
            wr_data_o   <= w_wr_data_next;
            frame_err_o <= w_err_next;
        end
    end

endmodule
